// File: rtl/issue_scheduler_if.sv
// ----------------------------------------------------------------------------
// issue_scheduler_if
// Groups the issue scheduler's handshake and data signals toward decode,
// queue_comps, the execute lane and writeback into one bundle.
//
// Parameters:
//   CW      occupancy counter width
//   AWIDTH  register address width
//
// Modports:
//   master  the issue scheduler itself (drives the is_o_* signals)
//   slave   the surrounding front end (drives the is_i_* signals)
// ----------------------------------------------------------------------------
interface issue_scheduler_if #(
  parameter int CW     = 4,
  parameter int AWIDTH = 5
);
  logic              is_i_dec_valid;
  logic              is_o_dec_ready;
  logic              is_o_q_we;
  logic              is_o_q_re;
  logic              is_o_q_rst;
  logic [AWIDTH-1:0] is_i_q_addr_rs;
  logic [AWIDTH-1:0] is_i_q_addr_rt;
  logic [AWIDTH-1:0] is_i_q_dst;
  logic              is_i_q_regwrite;
  logic              is_o_issue_valid;
  logic              is_i_exec_ready;
  logic              is_i_wb_valid;
  logic [AWIDTH-1:0] is_i_wb_addr;
  logic              is_i_flush;
  logic [CW-1:0]     is_o_count;
  logic              is_o_full;
  logic              is_o_empty;
  logic              is_o_stall_raw;

  modport master (
    input  is_i_dec_valid,
    output is_o_dec_ready,
    output is_o_q_we,
    output is_o_q_re,
    output is_o_q_rst,
    input  is_i_q_addr_rs,
    input  is_i_q_addr_rt,
    input  is_i_q_dst,
    input  is_i_q_regwrite,
    output is_o_issue_valid,
    input  is_i_exec_ready,
    input  is_i_wb_valid,
    input  is_i_wb_addr,
    input  is_i_flush,
    output is_o_count,
    output is_o_full,
    output is_o_empty,
    output is_o_stall_raw
  );

  modport slave (
    output is_i_dec_valid,
    input  is_o_dec_ready,
    input  is_o_q_we,
    input  is_o_q_re,
    input  is_o_q_rst,
    output is_i_q_addr_rs,
    output is_i_q_addr_rt,
    output is_i_q_dst,
    output is_i_q_regwrite,
    input  is_o_issue_valid,
    output is_i_exec_ready,
    output is_i_wb_valid,
    output is_i_wb_addr,
    output is_i_flush,
    input  is_o_count,
    input  is_o_full,
    input  is_o_empty,
    input  is_o_stall_raw
  );
endinterface

// File: rtl/issue_scheduler.sv
// ----------------------------------------------------------------------------
// issue_scheduler
// Controller for the decoded-instruction queue (queue_comps). Gates the queue
// write/read enables, tracks occupancy, holds the queue head in a one-entry
// issue slot and releases it to the execute lane only when neither source
// register is pending in a 32-entry RAW scoreboard.
//
// Optional feature (macro ISSUE_WB_BYPASS_EN):
//   defined   - a scoreboard hit on the register being written back this
//               cycle is ignored; the execute lane forwards the value.
//   undefined - the head waits until the pend bit has actually cleared.
//
// Ports:
//   is_clk   clock, rising edge
//   is_rst   synchronous reset, active-low
//   bus      issue_scheduler_if.master:
//     decode    : is_i_dec_valid / is_o_dec_ready
//     queue     : is_o_q_we, is_o_q_re, is_o_q_rst (active-low),
//                 head fields is_i_q_addr_rs/rt, is_i_q_dst, is_i_q_regwrite
//     execute   : is_o_issue_valid / is_i_exec_ready
//     writeback : is_i_wb_valid, is_i_wb_addr
//     control   : is_i_flush
//     status    : is_o_count, is_o_full, is_o_empty, is_o_stall_raw
// ----------------------------------------------------------------------------
module issue_scheduler #(
  parameter int DEPTH  = 8,
  parameter int CW     = 4,
  parameter int AWIDTH = 5
) (
  input  logic              is_clk,
  input  logic              is_rst,
  issue_scheduler_if.master bus
);

  localparam int            NREG    = 1 << AWIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_s;
  logic              full_r;
  logic              empty_r;
  logic [AWIDTH-1:0] head_rs_r;
  logic [AWIDTH-1:0] head_rt_r;
  logic [AWIDTH-1:0] head_dst_r;
  logic              head_rw_r;
  logic [NREG-1:0]   pend_r;
  logic [NREG-1:0]   pend_s;
  logic [NREG-1:0]   wb_mask_s;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   visible_pend_s;
  logic              dec_ready_s;
  logic              q_we_s;
  logic              q_re_s;
  logic              capture_s;
  logic              hazard_s;
  logic              issue_valid_s;
  logic              stall_raw_s;
  logic              issue_s;

  // One-hot decode of a register address.
  function automatic logic [NREG-1:0] reg_onehot(input logic [AWIDTH-1:0] addr);
    logic [NREG-1:0] vec;
    vec       = {NREG{1'b0}};
    vec[addr] = 1'b1;
    return vec;
  endfunction

  // Pending lookup; register 0 is hard-wired and can never be a hazard.
  function automatic logic reg_pending(input logic [NREG-1:0] pend,
                                       input logic [AWIDTH-1:0] addr);
    logic hit;
    if (addr == {AWIDTH{1'b0}}) begin
      hit = 1'b0;
    end else begin
      hit = pend[addr];
    end
    return hit;
  endfunction

  // Decode-side handshake and queue write enable.
  always_comb begin
    dec_ready_s = !full_r && !bus.is_i_flush;
    q_we_s      = bus.is_i_dec_valid && dec_ready_s;
  end

  // Registers hidden from the hazard check this cycle (bypass from writeback).
  always_comb begin
    wb_mask_s = {NREG{1'b0}};
`ifdef ISSUE_WB_BYPASS_EN
    if (bus.is_i_wb_valid) begin
      wb_mask_s = reg_onehot(bus.is_i_wb_addr);
    end else begin
      wb_mask_s = {NREG{1'b0}};
    end
`endif
  end

  // RAW hazard on the held head; a flush cycle never issues.
  always_comb begin
    visible_pend_s = pend_r & ~wb_mask_s;
    hazard_s       = reg_pending(visible_pend_s, head_rs_r) |
                     reg_pending(visible_pend_s, head_rt_r);
    if ((state_r == ST_HOLD) && !bus.is_i_flush) begin
      issue_valid_s = !hazard_s;
      stall_raw_s   = hazard_s;
    end else begin
      issue_valid_s = 1'b0;
      stall_raw_s   = 1'b0;
    end
    issue_s = issue_valid_s && bus.is_i_exec_ready;
  end

  // FSM next state, queue read enable and head capture strobe.
  always_comb begin
    state_s   = state_r;
    q_re_s    = 1'b0;
    capture_s = 1'b0;
    if (bus.is_i_flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_r != ZERO_C) begin
            q_re_s  = 1'b1;
            state_s = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          // Queue output is valid now, one cycle after the read.
          capture_s = 1'b1;
          state_s   = ST_HOLD;
        end
        ST_HOLD: begin
          if (issue_s) begin
            if (count_r != ZERO_C) begin
              q_re_s  = 1'b1;
              state_s = ST_FETCH;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Occupancy next value; a flush empties the queue.
  always_comb begin
    count_s = count_r;
    if (bus.is_i_flush) begin
      count_s = ZERO_C;
    end else if (q_we_s && !q_re_s) begin
      count_s = count_r + ONE_C;
    end else if (!q_we_s && q_re_s) begin
      count_s = count_r - ONE_C;
    end else begin
      count_s = count_r;
    end
  end

  // Scoreboard next value: clear first, then set, so a younger producer
  // issuing in the same cycle as an older writeback keeps the bit set.
  always_comb begin
    if (issue_s && head_rw_r && (head_dst_r != {AWIDTH{1'b0}})) begin
      set_mask_s = reg_onehot(head_dst_r);
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (bus.is_i_wb_valid) begin
      pend_s = (pend_r & ~reg_onehot(bus.is_i_wb_addr)) | set_mask_s;
    end else begin
      pend_s = pend_r | set_mask_s;
    end
    pend_s[0] = 1'b0;
  end

  // State, occupancy, status flags and scoreboard registers.
  always_ff @(posedge is_clk) begin
    if (!is_rst) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_C;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      pend_r  <= {NREG{1'b0}};
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      full_r  <= (count_s == DEPTH_C);
      empty_r <= (count_s == ZERO_C);
      pend_r  <= pend_s;
    end
  end

  // Head latch: loaded in FETCH, frozen in HOLD, dropped on flush or reset.
  always_ff @(posedge is_clk) begin
    if (!is_rst || bus.is_i_flush) begin
      head_rs_r  <= {AWIDTH{1'b0}};
      head_rt_r  <= {AWIDTH{1'b0}};
      head_dst_r <= {AWIDTH{1'b0}};
      head_rw_r  <= 1'b0;
    end else if (capture_s) begin
      head_rs_r  <= bus.is_i_q_addr_rs;
      head_rt_r  <= bus.is_i_q_addr_rt;
      head_dst_r <= bus.is_i_q_dst;
      head_rw_r  <= bus.is_i_q_regwrite;
    end else begin
      head_rs_r  <= head_rs_r;
      head_rt_r  <= head_rt_r;
      head_dst_r <= head_dst_r;
      head_rw_r  <= head_rw_r;
    end
  end

  assign bus.is_o_dec_ready   = dec_ready_s;
  assign bus.is_o_q_we        = q_we_s;
  assign bus.is_o_q_re        = q_re_s;
  assign bus.is_o_q_rst       = is_rst && !bus.is_i_flush;
  assign bus.is_o_issue_valid = issue_valid_s;
  assign bus.is_o_stall_raw   = stall_raw_s;
  assign bus.is_o_count       = count_r;
  assign bus.is_o_full        = full_r;
  assign bus.is_o_empty       = empty_r;

endmodule

// File: tb/tb_issue_scheduler.sv
// ----------------------------------------------------------------------------
// tb_issue_scheduler
// Directed, table-driven bench for issue_scheduler. Each table row is one
// clock cycle: inputs are applied on the falling edge and the outputs seen
// before the next rising edge are compared with hand-computed values. A small
// behavioural FIFO stands in for queue_comps (read data valid one cycle after
// the read enable, pointers cleared while is_o_q_rst is low).
// ----------------------------------------------------------------------------
module tb_issue_scheduler;

  logic clk;
  logic rst;
  logic [15:0] din;
  logic [15:0] qout;
  logic [15:0] qmem [0:7];
  logic [2:0]  wp;
  logic [2:0]  rp;
  int checks;
  int passed;

  issue_scheduler_if #(.CW(4), .AWIDTH(5)) bus ();

  issue_scheduler #(.DEPTH(8), .CW(4), .AWIDTH(5)) dut (
    .is_clk (clk),
    .is_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction record pushed into the queue: {rs, rt, dst, regwrite}.
  assign bus.is_i_q_addr_rs  = qout[15:11];
  assign bus.is_i_q_addr_rt  = qout[10:6];
  assign bus.is_i_q_dst      = qout[5:1];
  assign bus.is_i_q_regwrite = qout[0];

  // Behavioural queue_comps stand-in.
  always @(posedge clk) begin
    if (!bus.is_o_q_rst) begin
      wp <= 3'd0;
      rp <= 3'd0;
    end else begin
      if (bus.is_o_q_we) begin
        qmem[wp] <= din;
        wp <= wp + 3'd1;
      end
      if (bus.is_o_q_re) begin
        qout <= qmem[rp];
        rp <= rp + 3'd1;
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        dv;
    logic [15:0] ins;
    logic        er;
    logic        wbv;
    logic [4:0]  wba;
    logic        fl;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] ins(input int rs, input int rt, input int dst, input int rw);
    return {rs[4:0], rt[4:0], dst[4:0], rw[0]};
  endfunction

  // Expected vector: {count, full, empty, issue_valid, stall_raw, q_re,
  // dec_ready, q_we, q_rst}; q_we and q_rst follow from their defining
  // equations on the row's inputs and expected dec_ready.
  task automatic add(input int r, input int dv, input logic [15:0] in_ins,
                     input int er, input int wbv, input int wba, input int fl,
                     input int cnt, input int full, input int empty, input int iv,
                     input int st, input int re, input int rdy);
    vec_t v;
    v.rst = r[0];
    v.dv  = dv[0];
    v.ins = in_ins;
    v.er  = er[0];
    v.wbv = wbv[0];
    v.wba = wba[4:0];
    v.fl  = fl[0];
    v.exp = {cnt[3:0], full[0], empty[0], iv[0], st[0], re[0], rdy[0],
             dv[0] & rdy[0], r[0] & ~fl[0]};
    tbl.push_back(v);
  endtask

  initial begin
    logic [11:0] act;
    checks = 0;
    passed = 0;
    rst = 1'b0;
    din = 16'd0;
    qout = 16'd0;
    bus.is_i_dec_valid = 1'b0;
    bus.is_i_exec_ready = 1'b0;
    bus.is_i_wb_valid = 1'b0;
    bus.is_i_wb_addr = 5'd0;
    bus.is_i_flush = 1'b0;

    //   rst dv ins             er wbv wba fl | cnt full empty iv st re rdy
    // Reset state, then two hazard-free entries issued two cycles apart.
    add(0, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 1, ins(1,2,5,1),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 1, ins(3,4,6,1),     1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   1, 0, 0, 1, 0, 1, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 1, 5, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 1, 6, 0,   0, 0, 1, 0, 0, 0, 1);
    // Fill to DEPTH while the lane is blocked; first entry sets pend[7].
    add(1, 1, ins(1,1,7,1),     0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 1, ins(1,1,0,0),     0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1);
    add(1, 1, ins(1,1,0,0),     0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    for (int k = 2; k <= 7; k++) begin
      add(1, 1, ins(1,1,0,0),   0, 0, 0, 0,   k, 0, 0, 1, 0, 0, 1);
    end
    // Ninth write dropped while full, then one issue frees a slot.
    add(1, 1, ins(1,1,0,0),     0, 0, 0, 0,   8, 1, 0, 1, 0, 0, 0);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   8, 1, 0, 1, 0, 1, 0);
    add(1, 0, ins(0,0,0,0),     0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 1);
    // Flush with a head in HOLD and entries queued.
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 1,   7, 0, 0, 0, 0, 0, 0);
    // pend[7] survives the flush: an rs=7 head stalls until wb 7.
    add(1, 1, ins(7,1,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 1, 0, 1);
`ifdef ISSUE_WB_BYPASS_EN
    add(1, 0, ins(0,0,0,0),     1, 1, 7, 0,   0, 0, 1, 1, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
`else
    add(1, 0, ins(0,0,0,0),     1, 1, 7, 0,   0, 0, 1, 0, 1, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
`endif
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    // dst=0 never pends; dst=9 issued alongside wb 9 stays pending.
    add(1, 1, ins(1,2,0,1),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 1, ins(0,0,9,1),     1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1);
    add(1, 1, ins(9,0,0,0),     1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   2, 0, 0, 1, 0, 1, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 1, 9, 0,   1, 0, 0, 1, 0, 1, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 1, 0, 1);
`ifdef ISSUE_WB_BYPASS_EN
    add(1, 0, ins(0,0,0,0),     1, 1, 9, 0,   0, 0, 1, 1, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
`else
    add(1, 0, ins(0,0,0,0),     1, 1, 9, 0,   0, 0, 1, 0, 1, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
`endif
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    // Reset while a head is held: head and occupancy discarded.
    add(1, 1, ins(1,2,3,1),     0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 1, ins(1,2,3,1),     0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1);
    add(1, 0, ins(0,0,0,0),     0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 1);
    add(0, 0, ins(0,0,0,0),     0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
    add(1, 0, ins(0,0,0,0),     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);

    // Hold reset for four edges; the first table row is the fifth.
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ((bus.is_o_count !== 4'd0) || (bus.is_o_full !== 1'b0) ||
        (bus.is_o_empty !== 1'b1) || (bus.is_o_issue_valid !== 1'b0) ||
        (bus.is_o_stall_raw !== 1'b0) || (bus.is_o_q_re !== 1'b0)) begin
        $display("FAIL reset state: cnt=%0d full=%b empty=%b iv=%b stall=%b re=%b",
                 bus.is_o_count, bus.is_o_full, bus.is_o_empty,
                 bus.is_o_issue_valid, bus.is_o_stall_raw, bus.is_o_q_re);
    end else begin
        passed++;
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      bus.is_i_dec_valid = tbl[i].dv;
      din = tbl[i].ins;
      bus.is_i_exec_ready = tbl[i].er;
      bus.is_i_wb_valid = tbl[i].wbv;
      bus.is_i_wb_addr = tbl[i].wba;
      bus.is_i_flush = tbl[i].fl;
      #1;
      act = {bus.is_o_count, bus.is_o_full, bus.is_o_empty, bus.is_o_issue_valid,
             bus.is_o_stall_raw, bus.is_o_q_re, bus.is_o_dec_ready, bus.is_o_q_we,
             bus.is_o_q_rst};
      checks++;
      if (act !== tbl[i].exp) begin
        $display("FAIL row %0d: got cnt=%0d full/empty/iv/stall/re/rdy/we/qrst=%b, want cnt=%0d flags=%b",
                 i, act[11:8], act[7:0], tbl[i].exp[11:8], tbl[i].exp[7:0]);
      end else begin
        passed++;
      end
    end

    @(negedge clk);
    checks++;
    if ((bus.is_o_count !== 4'd0) || (bus.is_o_empty !== 1'b1) ||
        (bus.is_o_issue_valid !== 1'b0)) begin
        $display("FAIL final idle: cnt=%0d empty=%b iv=%b",
                 bus.is_o_count, bus.is_o_empty, bus.is_o_issue_valid);
    end else begin
        passed++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
